// File: rtl/beacon_keyer.sv
// Beacon keyer: a UART byte arms a burst count, then a trigger edge plays that many
// timed carrier bursts, framed by a holdoff before and a cooldown after.
module beacon_keyer #(
   parameter int ON_CYC  = 1024,
   parameter int OFF_CYC = 1024,
   parameter int HOLDOFF = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_dat,
   input  logic       rx_stb,
   input  logic       trig,
   output logic       tx_en,
   output logic       busy,
   output logic [7:0] burst_cnt,
   output logic       done
);
   localparam int MAXC = (ON_CYC > OFF_CYC) ? ((ON_CYC > HOLDOFF) ? ON_CYC : HOLDOFF)
                                            : ((OFF_CYC > HOLDOFF) ? OFF_CYC : HOLDOFF);
   localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYC - 1);
   localparam logic [CW-1:0] OFF_LAST = CW'(OFF_CYC - 1);
   localparam logic [CW-1:0] HO_LAST  = CW'(HOLDOFF - 1);

   typedef enum logic [2:0] {S_IDLE, S_ARMED, S_HOLD, S_ON, S_OFF, S_COOL} state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [7:0]    rem_q;
   logic [7:0]    burst_q;
   logic          trig_q;
   logic          tx_en_q;
   logic          busy_q;
   logic          done_q;

   logic          trig_edge;
   logic          abort;
   logic [CW-1:0] cnt_d;
   logic [7:0]    burst_d;

   assign trig_edge = trig & ~trig_q;
   assign abort     = rx_stb && (rx_dat == 8'h00);
   assign cnt_d     = cnt_q + 1'b1;
   assign burst_d   = (burst_q == 8'hFF) ? burst_q : burst_q + 8'd1;

   assign tx_en     = tx_en_q;
   assign busy      = busy_q;
   assign burst_cnt = burst_q;
   assign done      = done_q;

   // trig_q resets high so a trigger already asserted at release is not an edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rem_q   <= 8'd0;
         burst_q <= 8'd0;
         trig_q  <= 1'b1;
         tx_en_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         trig_q <= trig;
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (rx_stb && rx_dat != 8'h00) begin
                  state_q <= S_ARMED;
                  rem_q   <= rx_dat;
               end
            end
            S_ARMED: begin
               if (abort) begin
                  state_q <= S_IDLE;
               end else begin
                  if (rx_stb) rem_q <= rx_dat;
                  if (trig_edge) begin
                     state_q <= S_HOLD;
                     busy_q  <= 1'b1;
                     cnt_q   <= '0;
                     burst_q <= 8'd0;
                  end
               end
            end
            S_HOLD, S_ON, S_OFF, S_COOL: begin
               if (abort) begin
                  state_q <= S_IDLE;
                  tx_en_q <= 1'b0;
                  busy_q  <= 1'b0;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_d;
                  case (state_q)
                     S_HOLD: begin
                        if (cnt_q == HO_LAST) begin
                           state_q <= S_ON;
                           tx_en_q <= 1'b1;
                           cnt_q   <= '0;
                        end
                     end
                     S_ON: begin
                        if (cnt_q == ON_LAST) begin
                           tx_en_q <= 1'b0;
                           cnt_q   <= '0;
                           burst_q <= burst_d;
                           rem_q   <= rem_q - 8'd1;
                           state_q <= (rem_q == 8'd1) ? S_COOL : S_OFF;
                        end
                     end
                     S_OFF: begin
                        if (cnt_q == OFF_LAST) begin
                           state_q <= S_ON;
                           tx_en_q <= 1'b1;
                           cnt_q   <= '0;
                        end
                     end
                     S_COOL: begin
                        if (cnt_q == HO_LAST) begin
                           state_q <= S_IDLE;
                           busy_q  <= 1'b0;
                           done_q  <= 1'b1;
                           cnt_q   <= '0;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            default: begin
               state_q <= S_IDLE;
               tx_en_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end
endmodule
